// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag indices for the registered ALU.
package alu_pkg;

    localparam logic [3:0] OP_ZERO = 4'd0;
    localparam logic [3:0] OP_A    = 4'd1;
    localparam logic [3:0] OP_B    = 4'd2;
    localparam logic [3:0] OP_NEGA = 4'd3;
    localparam logic [3:0] OP_NEGB = 4'd4;
    localparam logic [3:0] OP_RORA = 4'd5;
    localparam logic [3:0] OP_RORB = 4'd6;
    localparam logic [3:0] OP_LTU  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_NOTA = 4'd9;
    localparam logic [3:0] OP_NOTB = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_ADD  = 4'd12;
    localparam logic [3:0] OP_OR   = 4'd13;
    localparam logic [3:0] OP_XOR  = 4'd14;
    localparam logic [3:0] OP_ONES = 4'd15;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int NFLAGS = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational op/flag evaluator; rotates pass the operand through
// unchanged, which is exactly the amt == 0 result.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  result,
    output logic [NFLAGS-1:0] flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        min_val = '0;
        min_val[WIDTH-1] = 1'b1;
    end

    always_comb begin
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ZERO: r = '0;
            OP_A:    r = a;
            OP_B:    r = b;
            OP_NEGA: begin
                r = '0 - a;
                v = (a == min_val);
            end
            OP_NEGB: begin
                r = '0 - b;
                v = (b == min_val);
            end
            OP_RORA: r = a;
            OP_RORB: r = b;
            OP_LTU:  r[0] = (a < b);
            OP_AND:  r = a & b;
            OP_NOTA: r = ~a;
            OP_NOTB: r = ~b;
            OP_SUB: begin
                r = diff[WIDTH-1:0];
                c = ~diff[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) &&
                    (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADD: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ONES: r = '1;
            default: r = '0;
        endcase
    end

    always_comb begin
        result = r;
        flags = '0;
        flags[FLAG_Z] = (r == '0);
        flags[FLAG_N] = r[WIDTH-1];
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; variable rotates run
// one bit per cycle in the ROT state.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  rot_q, rot_d, rot_nxt;
    logic [AMT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [NFLAGS-1:0] flg_q, flg_d;
    logic [WIDTH-1:0]  comb_res;
    logic [NFLAGS-1:0] comb_flg;
    logic              rot_op;
    logic [WIDTH-1:0]  rot_src;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (comb_res),
        .flags  (comb_flg)
    );

    assign rot_op  = (op == OP_RORA) || (op == OP_RORB);
    assign rot_src = (op == OP_RORA) ? a : b;
    assign rot_nxt = {rot_q[0], rot_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        rot_d     = rot_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        flg_d     = flg_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_ROT: begin
                busy  = 1'b1;
                rot_d = rot_nxt;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                    res_d = rot_nxt;
                    flg_d = '0;
                    flg_d[FLAG_Z] = (rot_nxt == '0);
                    flg_d[FLAG_N] = rot_nxt[WIDTH-1];
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !in_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Accept path shared by IDLE and a draining DONE
        if (in_valid && in_ready) begin
            if (rot_op && (amt != '0)) begin
                state_d = S_ROT;
                rot_d   = rot_src;
                cnt_d   = amt;
            end else begin
                state_d = S_DONE;
                res_d   = comb_res;
                flg_d   = comb_flg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rot_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign result = res_q;
    assign flag_z = flg_q[FLAG_Z];
    assign flag_n = flg_q[FLAG_N];
    assign flag_c = flg_q[FLAG_C];
    assign flag_v = flg_q[FLAG_V];

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit combinational ALU select. It accepts one operation per transfer on a valid/ready input handshake and returns a registered result plus Z/N/C/V flags on a valid/ready output handshake. Rotates by a variable amount run as a multi-cycle, one-bit-per-cycle sequence. It sits between the register-file read stage and the write-back stage of the datapath.

## Interface
- WIDTH, 8, operand/result width; legal range 4..32.
- AMT_W, $clog2(WIDTH), rotate-amount width; derived, do not override.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  op/a/b/amt valid.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- op  in  4  opcode (see Operation).
- a, b  in  WIDTH  operands (two's complement where signed).
- amt  in  AMT_W  rotate amount for ops 5/6.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- result  out  WIDTH  registered result.
- flag_z, flag_n, flag_c, flag_v  out  1 each  zero, MSB, carry, signed overflow.
- busy  out  1  high in ROT state.

## Operation
- Opcodes: 0 zero; 1 A; 2 B; 3 -A; 4 -B; 5 A ror amt; 6 B ror amt; 7 unsigned A<B → 1, else 0; 8 A&B; 9 ~A; 10 ~B; 11 A-B; 12 A+B; 13 A|B; 14 A^B; 15 all ones. No undefined codes.
- Arithmetic computed at WIDTH+1 bits. Add: C = carry-out, V = operands same sign and result sign differs. Sub: C = 1 when A>=B unsigned (no borrow), V = operand signs differ and result sign differs from A. Negate: C = 0, V = 1 only when operand == 100…0. All other ops: C = 0, V = 0.
- Z = (result == 0), N = result[WIDTH-1]. Flags are registered with result and always describe the current result.
- FSM, three states:
  - IDLE: in_ready = 1. On accept: ops 5/6 with amt != 0 → ROT, loading the operand into the rotate register and amt into a down-counter. All other ops → DONE with the result registered.
  - ROT: in_ready = 0, busy = 1. Each cycle: rotate right by 1 and decrement the counter. When the counter reaches 1, that cycle's rotate is the last and the next state is DONE.
  - DONE: out_valid = 1. in_ready = out_ready. If out_ready && in_valid, accept the new op in the same cycle (same rules as IDLE). If out_ready && !in_valid → IDLE. If !out_ready, hold result, flags and state.
- amt == 0 on ops 5/6 behaves as op 1/2, single-cycle.

## Timing
- Reset (async assert, sync release): state IDLE, result 0, all flags 0, out_valid 0, busy 0, in_ready 1 on the first cycle after release.
- Single-cycle ops: accept at edge N, out_valid high after edge N; latency 1. Sustained throughput is 1 op/cycle when out_ready is held high.
- Rotate: accept at edge N, out_valid high after edge N+amt; latency amt+1.
- Back-pressure: result, flags and out_valid stay stable while out_valid && !out_ready. Inputs are sampled only on an accept.
- Reset asserted mid-ROT or mid-DONE: the operation is abandoned, outputs go to reset values immediately, and the op is not replayed.

## Structure
- Shared package alu_pkg: opcode localparams (OP_ZERO … OP_ONES), FSM state encoding (S_IDLE, S_ROT, S_DONE), flag bit indices.
- One sub-module: alu_comb, a purely combinational WIDTH-parametrised op/flag evaluator, excluding multi-bit rotate. alu_seq holds the FSM, rotate register/counter and output registers.

## Test plan
- WIDTH=8, op 12, a=0x7F, b=0x01, out_ready=1 → next cycle result 0x80, N=1, V=1, C=0, Z=0.
- op 11, a=0x05, b=0x05 → result 0x00, Z=1, C=1, V=0. Then a=0x03, b=0x05 → 0xFE, C=0, N=1.
- op 5, a=0x96, amt=3 → busy for 3 cycles, in_ready=0, out_valid after edge N+3 with result 0xD2. Repeat with amt=0 → 0x96 after 1 cycle.
- Back-to-back op 1 with a=1,2,3,4 on consecutive cycles, out_ready=1 → results 1,2,3,4 on consecutive cycles with no bubbles. Then drop out_ready for 3 cycles → result held and in_ready=0.
- op 3, a=0x80 → result 0x80, V=1. op 7, a=0x01, b=0xFF → result 0x01.
- Assert rst_n low during cycle 2 of an amt=6 rotate → out_valid, busy and result 0 immediately. After release, op 2 with b=0x3C returns 0x3C in 1 cycle.
